// File: rtl/shift_extend_pkg.sv
// Shared definitions for the shift/extend pipeline: op-code enum and widths.
package shift_extend_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSL  = 3'd0,
    OP_LSR  = 3'd1,
    OP_ASR  = 3'd2,
    OP_ROR  = 3'd3,
    OP_SXTB = 3'd4,
    OP_UXTB = 3'd5,
    OP_SXTH = 3'd6,
    OP_UXTH = 3'd7
  } op_e;

endpackage

// File: rtl/shift_extend_core.sv
// Combinational shift/rotate/extend datapath with carry-out.
// Optional feature macro: SHIFT_EXTEND_COUT_EN (carry-out computed when defined,
// otherwise cout is tied low).
module shift_extend_core
  import shift_extend_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHAMT_W = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  input  op_e                op,
  input  logic               cin,
  output logic [DATA_W-1:0]  result,
  output logic               cout
);

  localparam int ROT_W = SHAMT_W - 1;

  // Shifts are done one bit wider than the datapath so the last bit shifted
  // out lands in the extra position and becomes the carry.
  logic [DATA_W:0]     lsl_w;
  logic [DATA_W:0]     lsr_w;
  logic [DATA_W:0]     asr_w;
  logic [2*DATA_W-1:0] ror_w;
  logic [SHAMT_W-1:0]  asr_amt;
  logic [ROT_W-1:0]    rot_amt;
  logic                carry;

  // Compute all candidate results, then select by op.
  always_comb begin
    lsl_w   = {1'b0, data} << amount;
    lsr_w   = {data, 1'b0} >> amount;
    // Saturating the ASR amount at DATA_W fills every bit (carry included) with the sign.
    asr_amt = (amount > SHAMT_W'(DATA_W)) ? SHAMT_W'(DATA_W) : amount;
    asr_w   = $signed({data, 1'b0}) >>> asr_amt;
    rot_amt = amount[ROT_W-1:0];
    ror_w   = {data, data} >> rot_amt;
    result  = data;
    carry   = cin;
    case (op)
      OP_LSL:  begin result = lsl_w[DATA_W-1:0]; carry = lsl_w[DATA_W];  end
      OP_LSR:  begin result = lsr_w[DATA_W:1];   carry = lsr_w[0];       end
      OP_ASR:  begin result = asr_w[DATA_W:1];   carry = asr_w[0];       end
      OP_ROR:  begin result = ror_w[DATA_W-1:0]; carry = ror_w[DATA_W-1]; end
      OP_SXTB: result = {{(DATA_W-8){data[7]}}, data[7:0]};
      OP_UXTB: result = {{(DATA_W-8){1'b0}}, data[7:0]};
      OP_SXTH: result = {{(DATA_W-16){data[15]}}, data[15:0]};
      OP_UXTH: result = {{(DATA_W-16){1'b0}}, data[15:0]};
    endcase
    // Nothing is shifted out at amount zero, so the carry passes through.
    if (amount == '0)
      carry = cin;
  end

`ifdef SHIFT_EXTEND_COUT_EN
  assign cout = carry;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign cout         = 1'b0;
`endif

endmodule

// File: rtl/shift_extend_pipe.sv
// Two-stage valid/ready shift/extend pipeline: S1 holds accepted operands,
// S2 holds the computed result. DATA_W must be a power of two, >= 16.
// Optional feature macro: SHIFT_EXTEND_COUT_EN (carry-in/carry-out path).
module shift_extend_pipe
  import shift_extend_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHAMT_W = $clog2(DATA_W) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic [2:0]         in_op,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_cout
);

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [SHAMT_W-1:0] s1_amount;
  op_e                s1_op;
  logic               s1_cin;
  logic               s1_adv;
  logic               s2_valid;
  logic [DATA_W-1:0]  s2_data;
  logic [DATA_W-1:0]  core_data;
  logic               core_cout;

  // S2 is free or draining this cycle, so S1 may move forward.
  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s1_adv);

  // S1: capture an accepted operand beat, or empty when S1 moves on with no new beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data   <= in_data;
        s1_amount <= in_amount;
        s1_op     <= op_e'(in_op);
      end
    end
  end

`ifdef SHIFT_EXTEND_COUT_EN
  // S1 carry-in, loaded alongside the operand.
  always_ff @(posedge clk) begin
    if (!rst && in_ready && in_valid)
      s1_cin <= in_cin;
  end
`else
  logic unused_cin;
  assign unused_cin = in_cin;
  assign s1_cin     = 1'b0;
`endif

  shift_extend_core #(.DATA_W(DATA_W)) u_core (
    .data   (s1_data),
    .amount (s1_amount),
    .op     (s1_op),
    .cin    (s1_cin),
    .result (core_data),
    .cout   (core_cout)
  );

  // S2: load the computed result when S1 advances; hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= core_data;
    end
  end

`ifdef SHIFT_EXTEND_COUT_EN
  logic s2_cout;

  // S2 carry-out, loaded alongside the result.
  always_ff @(posedge clk) begin
    if (rst)
      s2_cout <= 1'b0;
    else if (s1_adv && s1_valid)
      s2_cout <= core_cout;
  end

  assign out_cout = s2_cout;
`else
  logic unused_core_cout;
  assign unused_core_cout = core_cout;
  assign out_cout         = 1'b0;
`endif

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

endmodule

// File: tb/tb_shift_extend_pipe.sv
// Self-checking bench for shift_extend_pipe: bit-level reference model with a
// per-cycle scoreboard, plus literal expectations for key vectors.
module tb_shift_extend_pipe;

  localparam int W  = 32;
  localparam int SW = 6;
`ifdef SHIFT_EXTEND_COUT_EN
  localparam bit COUT_ON = 1'b1;
`else
  localparam bit COUT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amount = '0;
  logic [2:0]    in_op = '0;
  logic          in_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_cout;

  int errors = 0;
  int checks = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  shift_extend_pipe #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amount(in_amount), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cout(out_cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit definition of each operation.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] d, input int amt,
                                input logic cin, output logic [W-1:0] r, output logic c);
    r = '0;
    c = cin;
    case (op)
      3'd0: begin
        for (int i = 0; i < W; i++) r[i] = (i >= amt) ? d[i-amt] : 1'b0;
        if (amt >= 1 && amt <= W) c = d[W-amt]; else if (amt > W) c = 1'b0;
      end
      3'd1: begin
        for (int i = 0; i < W; i++) r[i] = (i + amt < W) ? d[i+amt] : 1'b0;
        if (amt >= 1 && amt <= W) c = d[amt-1]; else if (amt > W) c = 1'b0;
      end
      3'd2: begin
        for (int i = 0; i < W; i++) r[i] = (i + amt < W) ? d[i+amt] : d[W-1];
        if (amt >= 1 && amt < W) c = d[amt-1]; else if (amt >= W) c = d[W-1];
      end
      3'd3: begin
        for (int i = 0; i < W; i++) r[i] = d[(i+amt) % W];
        if (amt != 0) c = r[W-1];
      end
      3'd4: for (int i = 0; i < W; i++) r[i] = (i < 8)  ? d[i] : d[7];
      3'd5: for (int i = 0; i < W; i++) r[i] = (i < 8)  ? d[i] : 1'b0;
      3'd6: for (int i = 0; i < W; i++) r[i] = (i < 16) ? d[i] : d[15];
      default: for (int i = 0; i < W; i++) r[i] = (i < 16) ? d[i] : 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int           age;
  } exp_t;
  exp_t q[$];

  logic         prev_rst = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_cout = 1'b0;

  // Scoreboard: check outputs each cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [W-1:0] r;
    logic         c;
    logic         exp_ov;
    if (prev_rst) begin
      check("rst out_valid", out_valid, 0);
      check("rst out_data", out_data, 0);
      check("rst out_cout", out_cout, 0);
    end else begin
      // The oldest beat reaches S2 one edge after acceptance into S1.
      exp_ov = (q.size() > 0) && (q[0].age >= 2);
      check("out_valid", out_valid, exp_ov);
      if (out_valid && exp_ov) begin
        check("out_data", out_data, q[0].d);
        check("out_cout", out_cout, q[0].c);
      end
      if (prev_stall) begin
        check("stall data stable", out_data, prev_data);
        check("stall cout stable", out_cout, prev_cout);
      end
    end
    if (rst) check("rst in_ready", in_ready, 0);
    else     check("in_ready", in_ready, !(q.size() == 2 && !out_ready));

    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (in_valid && in_ready) begin
        model(in_op, in_data, int'(in_amount), in_cin, r, c);
        q.push_back('{d: r, c: COUT_ON ? c : 1'b0, age: 1});
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_data  = out_data;
    prev_cout  = out_cout;
    prev_rst   = rst;
  end

  // Pseudo-random consumer back-pressure when enabled.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input int amt, input logic cin);
    bit acc;
    int n;
    in_valid = 1'b1; in_op = op; in_data = d; in_amount = SW'(amt); in_cin = cin;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain timeout", 0, 1);
    tick();
  endtask

  task automatic directed(input string nm, input logic [2:0] op, input logic [W-1:0] d, input int amt,
                          input logic cin, input logic [W-1:0] ed, input logic ec);
    in_valid = 1'b1; in_op = op; in_data = d; in_amount = SW'(amt); in_cin = cin;
    @(negedge clk);
    check({nm, " accept"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, " valid after 1"}, out_valid, 0);
    @(negedge clk);
    check({nm, " valid after 2"}, out_valid, 1);
    check({nm, " data"}, out_data, ed);
    check({nm, " cout"}, out_cout, COUT_ON ? ec : 1'b0);
    tick();
  endtask

  typedef struct {
    string        nm;
    logic [2:0]   op;
    logic [W-1:0] d;
    int           amt;
    logic         cin;
    logic [W-1:0] ed;
    logic         ec;
  } vec_t;

  vec_t vecs[8] = '{
    '{"lsl1",    3'd0, 32'h8000_0001,  1, 1'b0, 32'h0000_0002, 1'b1},
    '{"asr40",   3'd2, 32'h8000_0000, 40, 1'b0, 32'hFFFF_FFFF, 1'b1},
    '{"lsr32",   3'd1, 32'h8000_0000, 32, 1'b0, 32'h0000_0000, 1'b1},
    '{"lsr0cin", 3'd1, 32'h8000_0000,  0, 1'b1, 32'h8000_0000, 1'b1},
    '{"ror4",    3'd3, 32'h0000_00F1,  4, 1'b1, 32'h1000_000F, 1'b0},
    '{"ror32",   3'd3, 32'h0000_00F1, 32, 1'b1, 32'h0000_00F1, 1'b0},
    '{"sxth",    3'd6, 32'h1234_8001,  7, 1'b1, 32'hFFFF_8001, 1'b1},
    '{"uxtb",    3'd5, 32'h1234_56F0,  3, 1'b0, 32'h0000_00F0, 1'b0}
  };

  int           amts[7] = '{0, 1, 5, 31, 32, 33, 63};
  logic [W-1:0] pats[3] = '{32'h8000_0001, 32'hA5A5_0F7E, 32'h7FFF_8080};

  initial begin
    logic [W-1:0] r;
    logic         c;

    // Pin the reference model against hand-computed values.
    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].d, vecs[i].amt, vecs[i].cin, r, c);
      check({"model ", vecs[i].nm, " data"}, r, vecs[i].ed);
      check({"model ", vecs[i].nm, " cout"}, c, vecs[i].ec);
    end

    repeat (3) tick();
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      directed(vecs[i].nm, vecs[i].op, vecs[i].d, vecs[i].amt, vecs[i].cin, vecs[i].ed, vecs[i].ec);

    // Short stream under random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      send(3'(i), pats[i % 3] ^ 32'(i * 32'h0101_0101), (i * 9) % 64, 1'(i));
    drain();

    // Every op against the boundary amounts, with gaps and back-pressure.
    rand_rdy = 1'b1;
    for (int op = 0; op < 8; op++)
      foreach (amts[a])
        foreach (pats[p]) begin
          send(3'(op), pats[p], amts[a], 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) tick();
        end
    drain();

    // Fill both stages under stall, then reset: nothing in flight may emerge.
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0F0F, 4, 1'b0);
    send(3'd1, 32'hF0F0_0000, 4, 1'b1);
    @(negedge clk);
    check("full before rst in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", in_ready, 1);
    check("post-rst out_valid", out_valid, 0);
    repeat (5) tick();

    directed("lsl1 again", 3'd0, 32'h8000_0001, 1, 1'b0, 32'h0000_0002, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_extend_pipe.md
SHIFT_EXTEND_PIPE -- requirements
Module: shift_extend_pipe

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; SHALL be a power of two and at least 16.
REQ-002 Parameter: SHAMT_W, $clog2(DATA_W)+1, shift-amount width (derived, not overridden).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_data  input  DATA_W  operand.
REQ-008 in_amount  input  SHAMT_W  shift/rotate amount, unsigned.
REQ-009 in_op  input  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 SXTB, 5 UXTB, 6 SXTH, 7 UXTH.
REQ-010 in_cin  input  1  carry-in, passed through where no bit is shifted out.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  DATA_W  result.
REQ-014 out_cout  output  1  carry-out.

Function
REQ-015 Transfer occurs on valid&&ready at each port; out_valid, out_data, out_cout SHALL hold stable while out_valid&&!out_ready.
REQ-016 Two registered stages: S1 captures accepted operands; S2 holds computed result driving out_*; latency exactly 2 cycles from input transfer to out_valid with no stall; throughput one beat per cycle.
REQ-017 S1 advances when !s2_valid || out_ready; in_ready = !rst && (!s1_valid || S1 advances); no beat SHALL be dropped or duplicated under any back-pressure pattern.
REQ-018 LSL: amount 0 -> data unchanged, cout=cin; 1..DATA_W -> data<<amount, cout=in_data[DATA_W-amount]; >DATA_W -> 0, cout=0.
REQ-019 LSR: amount 0 -> unchanged, cout=cin; 1..DATA_W -> data>>amount, cout=in_data[amount-1]; >DATA_W -> 0, cout=0.
REQ-020 ASR: amount 0 -> unchanged, cout=cin; 1..DATA_W-1 -> sign-filled shift, cout=in_data[amount-1]; >=DATA_W -> all bits = sign, cout = sign.
REQ-021 ROR: amount 0 -> unchanged, cout=cin; otherwise rotate right by amount mod DATA_W, cout = result MSB (amount a multiple of DATA_W gives unchanged data, cout=MSB).
REQ-022 SXTB/UXTB/SXTH/UXTH: sign/zero-extend in_data[7:0] or [15:0] to DATA_W; in_amount ignored; cout=cin.
REQ-023 Simultaneous input and output transfer in the same cycle with both stages full SHALL be supported without bubble.

Reset
REQ-024 While rst high: s1_valid, s2_valid, out_valid = 0; out_data = 0; out_cout = 0; in_ready = 0.
REQ-025 rst asserted mid-operation SHALL discard all in-flight beats; first cycle after rst deasserts in_ready = 1.

Configuration
REQ-026 Macro SHIFT_EXTEND_COUT_EN: defined -> out_cout per REQ-018..022; undefined -> out_cout tied 0 and carry logic and in_cin path removed (in_cin unused).

Structure
REQ-027 Package shift_extend_pkg SHALL hold the op-code typedef (3-bit enum) and named op constants; both modules import it.
REQ-028 Combinational compute SHALL sit in sub-module shift_extend_core (data, amount, op, cin -> result, cout), instantiated between S1 and S2.

Verification
REQ-029 DATA_W=32, LSL, data 0x8000_0001, amount 1, cin 0 -> out_data 0x0000_0002, cout 1, out_valid exactly 2 cycles after accept.
REQ-030 ASR, data 0x8000_0000, amount 40 -> 0xFFFF_FFFF, cout 1; LSR same data amount 32 -> 0x0000_0000, cout 1; amount 0 with cin 1 -> data unchanged, cout 1.
REQ-031 ROR, data 0x0000_00F1, amount 4 -> 0x1000_000F, cout 0; amount 32 -> 0x0000_00F1, cout 0; SXTH data 0x1234_8001 -> 0xFFFF_8001, cout=cin.
REQ-032 Stream 8 beats with out_ready toggling pseudo-randomly -> 8 results in order, none lost, outputs stable while stalled, in_ready low only when both stages full and out_ready low.
REQ-033 Assert rst for one cycle with both stages full -> out_valid 0 next cycle, no stale result emitted afterwards; repeat REQ-029 with SHIFT_EXTEND_COUT_EN undefined -> cout 0, data unchanged.
